// File: rtl/fast_pipeline_tag.sv
`default_nettype none
// ============================================================================
// Module      : fast_pipeline_tag
// Description : Two-channel AXI-Stream stage with SOF metadata tagging,
//               whole-frame enable gating and saturating frame counters.
// Revision    : 1.0 - initial release
// ============================================================================

module fast_pipeline_tag_ch #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 128,
    parameter int TS_WIDTH   = 64,
    parameter int SEQ_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int PORT_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    input  logic                  m_tready,
    input  logic                  en,
    input  logic [TS_WIDTH-1:0]   ts,
    input  logic                  ts_step,
    output logic [CNT_WIDTH-1:0]  frames_pass,
    output logic [CNT_WIDTH-1:0]  frames_drop
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [7:0]           c_port_id = 8'(PORT_ID);
    localparam logic [SEQ_WIDTH-1:0] c_seq_one = SEQ_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    state_t                r_state;
    logic                  r_ready;
    logic                  r_out_valid, r_skid_valid;
    logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;
    logic [KEEP_WIDTH-1:0] r_out_keep, r_skid_keep;
    logic                  r_out_last, r_skid_last;
    logic [USER_WIDTH-1:0] r_out_user, r_skid_user;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic                  r_step;
    logic [CNT_WIDTH-1:0]  r_pass, r_drop;

    logic                  w_accept, w_sof, w_fwd, w_sof_fwd, w_sof_drop, w_emit;
    logic                  w_out_free, w_load_out_skid, w_load_out_in, w_load_skid;
    logic                  w_out_valid_next, w_skid_valid_next, w_drop_next;
    logic [USER_WIDTH-1:0] w_user;

    assign w_accept   = s_tvalid & r_ready;
    assign w_sof      = (r_state == ST_IDLE);
    assign w_fwd      = w_accept & (w_sof ? en : (r_state == ST_PASS));
    assign w_sof_fwd  = w_accept & w_sof & en;
    assign w_sof_drop = w_accept & w_sof & ~en;
    assign w_emit     = r_out_valid & m_tready;

    // Skid entry drains into the output register first so beat order holds.
    assign w_out_free        = ~r_out_valid | w_emit;
    assign w_load_out_skid   = w_out_free & r_skid_valid;
    assign w_load_out_in     = w_out_free & ~r_skid_valid & w_fwd;
    assign w_load_skid       = w_fwd & ~w_load_out_in;
    assign w_out_valid_next  = (r_out_valid & ~w_emit) | w_load_out_skid | w_load_out_in;
    assign w_skid_valid_next = (r_skid_valid & ~w_load_out_skid) | w_load_skid;
    assign w_drop_next       = ((r_state == ST_DROP) & ~(w_accept & s_tlast))
                             | (w_sof_drop & ~s_tlast);

    always_comb begin
        w_user = s_tuser;
        if (w_sof) begin
            w_user[TS_WIDTH-1:0]                   = ts;
            w_user[TS_WIDTH +: SEQ_WIDTH]          = r_seq;
            w_user[TS_WIDTH+SEQ_WIDTH +: 8]        = c_port_id;
            w_user[TS_WIDTH+SEQ_WIDTH+8]           = r_step | ts_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_out_user   <= '0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_user  <= '0;
            r_seq        <= '0;
            r_step       <= 1'b0;
            r_pass       <= '0;
            r_drop       <= '0;
        end else begin
            r_ready      <= w_drop_next | ~(w_out_valid_next & w_skid_valid_next);
            r_out_valid  <= w_out_valid_next;
            r_skid_valid <= w_skid_valid_next;

            if (w_load_skid) begin
                r_skid_data <= s_tdata;
                r_skid_keep <= s_tkeep;
                r_skid_last <= s_tlast;
                r_skid_user <= w_user;
            end

            if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_keep <= r_skid_keep;
                r_out_last <= r_skid_last;
                r_out_user <= r_skid_user;
            end else if (w_load_out_in) begin
                r_out_data <= s_tdata;
                r_out_keep <= s_tkeep;
                r_out_last <= s_tlast;
                r_out_user <= w_user;
            end

            // Single-beat frames are decided entirely in IDLE.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !s_tlast)
                        r_state <= en ? ST_PASS : ST_DROP;
                end
                ST_PASS, ST_DROP: begin
                    if (w_accept && s_tlast)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_sof_fwd)
                r_seq <= r_seq + c_seq_one;

            if (w_sof_fwd)
                r_step <= 1'b0;
            else if (ts_step)
                r_step <= 1'b1;

            if (w_sof_fwd && (r_pass != '1))
                r_pass <= r_pass + c_cnt_one;
            if (w_sof_drop && (r_drop != '1))
                r_drop <= r_drop + c_cnt_one;
        end
    end

    assign s_tready    = r_ready;
    assign m_tvalid    = r_out_valid;
    assign m_tdata     = r_out_data;
    assign m_tkeep     = r_out_keep;
    assign m_tlast     = r_out_last;
    assign m_tuser     = r_out_user;
    assign frames_pass = r_pass;
    assign frames_drop = r_drop;

endmodule

module fast_pipeline_tag #(
    parameter int DATA_WIDTH   = 256,
    parameter int KEEP_WIDTH   = DATA_WIDTH/8,
    parameter int USER_WIDTH   = 128,
    parameter int PTP_TS_WIDTH = 96,
    parameter int TS_WIDTH     = 64,
    parameter int SEQ_WIDTH    = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int PORT_ID      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tx_int_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tx_int_tkeep,
    input  logic                    s_axis_tx_int_tvalid,
    input  logic                    s_axis_tx_int_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tx_int_tuser,
    output logic                    s_axis_tx_int_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tx_fast_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tx_fast_tkeep,
    output logic                    m_axis_tx_fast_tvalid,
    output logic                    m_axis_tx_fast_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tx_fast_tuser,
    input  logic                    m_axis_tx_fast_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_rx_fast_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_rx_fast_tkeep,
    input  logic                    s_axis_rx_fast_tvalid,
    input  logic                    s_axis_rx_fast_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_rx_fast_tuser,
    output logic                    s_axis_rx_fast_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_rx_int_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_rx_int_tkeep,
    output logic                    m_axis_rx_int_tvalid,
    output logic                    m_axis_rx_int_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_rx_int_tuser,
    input  logic                    m_axis_rx_int_tready,
    input  logic                    tx_en,
    input  logic                    rx_en,
    input  logic [PTP_TS_WIDTH-1:0] ptp_ts_96,
    input  logic                    ptp_ts_step,
    output logic [CNT_WIDTH-1:0]    tx_frames_pass,
    output logic [CNT_WIDTH-1:0]    tx_frames_drop,
    output logic [CNT_WIDTH-1:0]    rx_frames_pass,
    output logic [CNT_WIDTH-1:0]    rx_frames_drop
);
    if (USER_WIDTH < TS_WIDTH + SEQ_WIDTH + 9) begin : g_user_width_check
        $error("USER_WIDTH too small for the SOF metadata header");
    end

    // Only the low TS_WIDTH bits of PTP time are stamped.
    logic w_unused_ptp;
    assign w_unused_ptp = ^ptp_ts_96;

    fast_pipeline_tag_ch #(
        .DATA_WIDTH (DATA_WIDTH), .KEEP_WIDTH (KEEP_WIDTH), .USER_WIDTH (USER_WIDTH),
        .TS_WIDTH   (TS_WIDTH),   .SEQ_WIDTH  (SEQ_WIDTH),  .CNT_WIDTH  (CNT_WIDTH),
        .PORT_ID    (PORT_ID)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_axis_tx_int_tdata),
        .s_tkeep     (s_axis_tx_int_tkeep),
        .s_tvalid    (s_axis_tx_int_tvalid),
        .s_tlast     (s_axis_tx_int_tlast),
        .s_tuser     (s_axis_tx_int_tuser),
        .s_tready    (s_axis_tx_int_tready),
        .m_tdata     (m_axis_tx_fast_tdata),
        .m_tkeep     (m_axis_tx_fast_tkeep),
        .m_tvalid    (m_axis_tx_fast_tvalid),
        .m_tlast     (m_axis_tx_fast_tlast),
        .m_tuser     (m_axis_tx_fast_tuser),
        .m_tready    (m_axis_tx_fast_tready),
        .en          (tx_en),
        .ts          (ptp_ts_96[TS_WIDTH-1:0]),
        .ts_step     (ptp_ts_step),
        .frames_pass (tx_frames_pass),
        .frames_drop (tx_frames_drop)
    );

    fast_pipeline_tag_ch #(
        .DATA_WIDTH (DATA_WIDTH), .KEEP_WIDTH (KEEP_WIDTH), .USER_WIDTH (USER_WIDTH),
        .TS_WIDTH   (TS_WIDTH),   .SEQ_WIDTH  (SEQ_WIDTH),  .CNT_WIDTH  (CNT_WIDTH),
        .PORT_ID    (PORT_ID)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_axis_rx_fast_tdata),
        .s_tkeep     (s_axis_rx_fast_tkeep),
        .s_tvalid    (s_axis_rx_fast_tvalid),
        .s_tlast     (s_axis_rx_fast_tlast),
        .s_tuser     (s_axis_rx_fast_tuser),
        .s_tready    (s_axis_rx_fast_tready),
        .m_tdata     (m_axis_rx_int_tdata),
        .m_tkeep     (m_axis_rx_int_tkeep),
        .m_tvalid    (m_axis_rx_int_tvalid),
        .m_tlast     (m_axis_rx_int_tlast),
        .m_tuser     (m_axis_rx_int_tuser),
        .m_tready    (m_axis_rx_int_tready),
        .en          (rx_en),
        .ts          (ptp_ts_96[TS_WIDTH-1:0]),
        .ts_step     (ptp_ts_step),
        .frames_pass (rx_frames_pass),
        .frames_drop (rx_frames_drop)
    );

endmodule
`default_nettype wire

// File: doc/fast_pipeline_tag.md
# fast_pipeline_tag

Parametrised two-channel AXI-Stream pipeline stage for the FAST port datapath. It sits between the corundum port logic and the FAST pipeline: TX runs int→fast, RX runs fast→int. Each channel registers traffic through a full-throughput skid buffer and stamps a metadata header into tuser on the first beat of each frame. It also gates whole frames by a per-channel enable, never truncating a frame mid-way, and keeps saturating pass/drop counters.

## Interface
Parameters:
- DATA_WIDTH, 256, tdata width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 128, tuser width; must be ≥ TS_WIDTH+SEQ_WIDTH+9
- PTP_TS_WIDTH, 96, PTP clock width
- TS_WIDTH, 64, low timestamp bits inserted
- SEQ_WIDTH, 16, frame sequence number width
- CNT_WIDTH, 32, statistics counter width
- PORT_ID, 0, 8-bit port identifier inserted

Ports (ch ∈ {tx, rx}; tx: s=*_int, m=*_fast; rx: s=*_fast, m=*_int):
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- s_axis_{ch}_tdata/tkeep/tvalid/tlast/tuser  in  DATA/KEEP/1/1/USER  slave stream
- s_axis_{ch}_tready  out  1
- m_axis_{ch}_tdata/tkeep/tvalid/tlast/tuser  out  DATA/KEEP/1/1/USER  master stream
- m_axis_{ch}_tready  in  1
- {ch}_en  in  1  frame pass enable, sampled at SOF
- ptp_ts_96  in  PTP_TS_WIDTH  current PTP time
- ptp_ts_step  in  1  PTP clock stepped pulse
- {ch}_frames_pass  out  CNT_WIDTH  frames forwarded
- {ch}_frames_drop  out  CNT_WIDTH  frames discarded

## Operation
- Channels are identical and independent; ptp inputs are shared.
- SOF is the first accepted beat after reset or after an accepted tlast beat.
- Per-channel FSM:
  - IDLE: at an accepted SOF, en=1 → beat forwarded, go to PASS; en=0 → beat discarded, go to DROP.
  - Exception in IDLE: a single-beat frame (tlast on the SOF beat) is forwarded or dropped in the same way, but the FSM stays in IDLE.
  - PASS: forward beats; accepted tlast → IDLE.
  - DROP: s_tready=1 unconditionally; discard beats; accepted tlast → IDLE.
- en changes mid-frame are ignored.
- SOF tuser rewrite on forwarded frames:
  - [TS_WIDTH-1:0] = ptp_ts_96[TS_WIDTH-1:0] in the accept cycle.
  - next SEQ_WIDTH bits = seq.
  - next 8 bits = PORT_ID.
  - next bit = step flag.
  - upper bits pass from input.
- Non-SOF beats pass tuser unchanged. tdata/tkeep/tlast always pass unchanged.
- seq:
  - Starts at 0; increments after each forwarded frame's SOF.
  - Wraps modulo 2^SEQ_WIDTH.
  - Dropped frames do not consume a seq value.
- Step flag:
  - Sticky; set by ptp_ts_step.
  - Reported on, then cleared by, the next forwarded SOF.
  - ptp_ts_step in the same cycle as that SOF is reported on that SOF. Flag is cleared; not re-set by that same pulse.
  - Dropped SOFs do not clear it.
- Counters:
  - frames_pass increments at a forwarded SOF; frames_drop at a dropped SOF.
  - Both saturate at all-ones.
- Skid buffer: 2 entries; s_tready is registered, = entry count < 2 (or 1 in DROP).

## Timing
- Reset values: all m_tvalid=0, s_tready=0; m_tdata/tkeep/tlast/tuser=0; counters 0; seq 0; step flag 0; FSM IDLE.
- Reset assertion mid-frame discards buffered beats immediately.
- First cycle after reset release: s_tready=1.
- Latency: 1 cycle from accept to m_tvalid when the buffer is empty.
- Throughput: 1 beat/cycle sustained while m_tready=1.
- Backpressure:
  - m_tvalid, once high, holds with stable payload until m_tready.
  - s_tready falls the cycle after the second entry fills.
  - No beat is lost or duplicated.
- Counters and seq update on the clock edge that accepts the SOF.
- Simultaneous accept-in and emit-out keeps the occupancy constant.

## Test plan
- Pass, defaults: tx_en=1, three 4-beat frames, ptp_ts_96 low bits = 0x100, 0x200, 0x300 at each SOF → SOF tuser ts = 0x100/0x200/0x300, seq 0/1/2, port 0; tx_frames_pass=3; output 1 cycle behind input.
- Drop gating: rx_en=0 at SOF of frame A; toggle rx_en=1 mid-frame A; frame B follows → A fully discarded with s_tready high throughout; B forwarded with seq=0; rx_frames_drop=1, rx_frames_pass=1.
- Backpressure: m_tready pattern 1,0,0,1 during a continuous 8-beat frame → s_tready low exactly one cycle after 2 beats are buffered; output beat order/data identical to input.
- Wrap and saturation: SEQ_WIDTH=4, CNT_WIDTH=4, 18 single-beat frames → seq sequence 0..15,0,1; frames_pass stuck at 15.
- Step flag: ptp_ts_step pulse, then a dropped frame, then a forwarded frame with a step pulse on its SOF cycle, then a forwarded frame → flag=1 on first forwarded SOF only; next forwarded SOF flag=0.
- Reset mid-frame: assert rst_n low on beat 2 of 4 with 2 beats buffered → m_tvalid=0 asynchronously; after release, the next beat is treated as SOF with seq=0.
